// File: rtl/eindopdracht_nios2_qsys_0_oci_dct_packer_if.sv
// Frame handshake between the trace-code packer (master) and the trace FIFO (slave).
// DCT_TIMESTAMP_EN adds the frm_ts sideband.
interface eindopdracht_nios2_qsys_0_oci_dct_packer_if;
    logic        frm_valid;
    logic        frm_ready;
    logic [29:0] frm_data;
    logic [3:0]  frm_count;
`ifdef DCT_TIMESTAMP_EN
    logic [15:0] frm_ts;

    modport master (output frm_valid, frm_data, frm_count, frm_ts, input frm_ready);
    modport slave  (input frm_valid, frm_data, frm_count, frm_ts, output frm_ready);
`else
    modport master (output frm_valid, frm_data, frm_count, input frm_ready);
    modport slave  (input frm_valid, frm_data, frm_count, output frm_ready);
`endif
endinterface

// File: rtl/eindopdracht_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit instruction trace codes into 30-bit frames for the OCI trace FIFO.
// Optional DCT_TIMESTAMP_EN: stamps each emitted frame with a free-running cycle count.
module eindopdracht_nios2_qsys_0_oci_dct_packer #(
    parameter int MAX_CODES = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        trc_on,
    input  logic        code_valid,
    input  logic [1:0]  code,
    input  logic        flush_req,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        overflow,
    input  logic        ovf_clr,
    eindopdracht_nios2_qsys_0_oci_dct_packer_if.master frm
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state;
    logic        accept;
    logic        flush_any;
    logic        emit;
    logic        load;
    logic        drop;
    logic [3:0]  count_next;
    logic [29:0] buf_next;

    always_comb begin
        accept     = (state == RUN) && code_valid;
        count_next = dct_count + {3'b0, accept};
        buf_next   = dct_buffer;
        if (accept)
            buf_next = dct_buffer | (30'(code) << {dct_count, 1'b0});
        // Leaving RUN drains whatever is still buffered.
        flush_any  = flush_req || ((state == RUN) && !trc_on);
        emit       = (count_next == 4'(MAX_CODES)) || (flush_any && (count_next != 4'd0));
        load       = emit && (!frm.frm_valid || frm.frm_ready);
        drop       = emit && frm.frm_valid && !frm.frm_ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            dct_buffer    <= '0;
            dct_count     <= '0;
            frm.frm_valid <= 1'b0;
            frm.frm_data  <= '0;
            frm.frm_count <= '0;
            overflow      <= 1'b0;
        end else begin
            state <= trc_on ? RUN : IDLE;

            if (emit) begin
                dct_buffer <= '0;
                dct_count  <= '0;
            end else if (accept) begin
                dct_buffer <= buf_next;
                dct_count  <= count_next;
            end

            if (load) begin
                frm.frm_valid <= 1'b1;
                frm.frm_data  <= buf_next;
                frm.frm_count <= count_next;
            end else if (frm.frm_ready) begin
                frm.frm_valid <= 1'b0;
            end

            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

`ifdef DCT_TIMESTAMP_EN
    logic [15:0] ts_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt     <= '0;
            frm.frm_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
            if (load)
                frm.frm_ts <= ts_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_eindopdracht_nios2_qsys_0_oci_dct_packer.sv
// Bench for the trace-code packer: vector table, directed corner sequences, random vs queue model.
module tb_eindopdracht_nios2_qsys_0_oci_dct_packer;

    localparam int MAXC = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trc_on, code_valid, flush_req, ovf_clr;
    logic [1:0]  code;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;

    int n_chk  = 0;
    int n_pass = 0;

    eindopdracht_nios2_qsys_0_oci_dct_packer_if bus ();

    eindopdracht_nios2_qsys_0_oci_dct_packer #(.MAX_CODES(MAXC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .trc_on     (trc_on),
        .code_valid (code_valid),
        .code       (code),
        .flush_req  (flush_req),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .frm        (bus.master)
    );

    always #5 clk = ~clk;

    // Reference model: pending codes in a queue, one held frame, sticky drop flag.
    int          mq[$];
    bit          mrun, mfv, movf;
    logic [29:0] mfd;
    logic [3:0]  mfc;
    logic [15:0] mts;
    logic [15:0] tb_cyc;

    always @(posedge clk or negedge reset_n)
        if (!reset_n) tb_cyc <= '0;
        else          tb_cyc <= tb_cyc + 16'd1;

    function automatic logic [29:0] pack(input int q[$]);
        logic [29:0] v = '0;
        for (int i = 0; i < q.size(); i++)
            v = v + (30'(q[i]) * (30'd1 << (2 * i)));
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        mrun = 0; mfv = 0; movf = 0; mfd = '0; mfc = '0; mts = '0;
    endtask

    task automatic model_step(input bit t, cv, input int c, input bit fl, rdy, clr);
        bit implicit_fl, em, dropped;
        if (mrun && cv) mq.push_back(c);
        implicit_fl = mrun && !t;
        em = (mq.size() == MAXC) || ((fl || implicit_fl) && mq.size() > 0);
        dropped = 0;
        if (em) begin
            if (!mfv || rdy) begin
                mfv = 1; mfd = pack(mq); mfc = 4'(mq.size()); mts = tb_cyc;
            end else begin
                dropped = 1;
            end
            mq.delete();
        end else if (rdy) begin
            mfv = 0;
        end
        if (dropped)   movf = 1;
        else if (clr)  movf = 0;
        mrun = t;
    endtask

    task automatic model_cmp();
        chk("dct_count",  {28'b0, dct_count},    32'(mq.size()));
        chk("dct_buffer", {2'b0, dct_buffer},    {2'b0, pack(mq)});
        chk("frm_valid",  {31'b0, bus.frm_valid}, {31'b0, mfv});
        chk("overflow",   {31'b0, overflow},      {31'b0, movf});
        if (mfv) begin
            chk("frm_data",  {2'b0, bus.frm_data},   {2'b0, mfd});
            chk("frm_count", {28'b0, bus.frm_count}, {28'b0, mfc});
`ifdef DCT_TIMESTAMP_EN
            chk("frm_ts",    {16'b0, bus.frm_ts},    {16'b0, mts});
`endif
        end
    endtask

    task automatic cyc(input bit t, cv, input logic [1:0] c, input bit fl, rdy, clr);
        trc_on = t; code_valid = cv; code = c; flush_req = fl; bus.frm_ready = rdy; ovf_clr = clr;
        model_step(t, cv, int'(c), fl, rdy, clr);
        @(posedge clk);
        #1;
        model_cmp();
    endtask

    task automatic do_reset();
        trc_on = 0; code_valid = 0; code = 0; flush_req = 0; bus.frm_ready = 0; ovf_clr = 0;
        reset_n = 1'b0;
        #2;
        chk("rst dct_count",  {28'b0, dct_count},     32'd0);
        chk("rst dct_buffer", {2'b0, dct_buffer},     32'd0);
        chk("rst frm_valid",  {31'b0, bus.frm_valid}, 32'd0);
        chk("rst frm_data",   {2'b0, bus.frm_data},   32'd0);
        chk("rst frm_count",  {28'b0, bus.frm_count}, 32'd0);
        chk("rst overflow",   {31'b0, overflow},      32'd0);
`ifdef DCT_TIMESTAMP_EN
        chk("rst frm_ts",     {16'b0, bus.frm_ts},    32'd0);
`endif
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    typedef struct {
        bit          t, cv;
        logic [1:0]  c;
        bit          fl, rdy, clr;
        logic [3:0]  e_cnt;
        logic [29:0] e_buf;
        bit          e_fv;
        logic [3:0]  e_fcnt;
        logic [29:0] e_fdata;
        bit          e_ovf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // Three 10 codes with flush on the third, then flush on an empty buffer.
        vecs[0] = '{1, 0, 2'd0, 0, 0, 0, 4'd0, 30'h0, 0, 4'd0, 30'h0,  0};
        vecs[1] = '{1, 1, 2'd2, 0, 0, 0, 4'd1, 30'h2, 0, 4'd0, 30'h0,  0};
        vecs[2] = '{1, 1, 2'd2, 0, 0, 0, 4'd2, 30'hA, 0, 4'd0, 30'h0,  0};
        vecs[3] = '{1, 1, 2'd2, 1, 0, 0, 4'd0, 30'h0, 1, 4'd3, 30'h2A, 0};
        vecs[4] = '{1, 0, 2'd0, 1, 1, 0, 4'd0, 30'h0, 0, 4'd0, 30'h0,  0};
        vecs[5] = '{1, 0, 2'd0, 1, 1, 0, 4'd0, 30'h0, 0, 4'd0, 30'h0,  0};
        vecs[6] = '{1, 1, 2'd3, 0, 1, 0, 4'd1, 30'h3, 0, 4'd0, 30'h0,  0};
        vecs[7] = '{1, 1, 2'd1, 0, 1, 1, 4'd2, 30'h7, 0, 4'd0, 30'h0,  0};

        do_reset();
        foreach (vecs[i]) begin
            cyc(vecs[i].t, vecs[i].cv, vecs[i].c, vecs[i].fl, vecs[i].rdy, vecs[i].clr);
            chk($sformatf("vec%0d cnt", i), {28'b0, dct_count},     {28'b0, vecs[i].e_cnt});
            chk($sformatf("vec%0d buf", i), {2'b0, dct_buffer},     {2'b0, vecs[i].e_buf});
            chk($sformatf("vec%0d fv", i),  {31'b0, bus.frm_valid}, {31'b0, vecs[i].e_fv});
            chk($sformatf("vec%0d ovf", i), {31'b0, overflow},      {31'b0, vecs[i].e_ovf});
            if (vecs[i].e_fv) begin
                chk($sformatf("vec%0d fcnt", i),  {28'b0, bus.frm_count}, {28'b0, vecs[i].e_fcnt});
                chk($sformatf("vec%0d fdata", i), {2'b0, bus.frm_data},   {2'b0, vecs[i].e_fdata});
            end
        end

        // Full frame, codes 01,10,11,00,... back-to-back.
        do_reset();
        cyc(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < MAXC; i++) begin
            cyc(1, 1, 2'((i + 1) % 4), 0, 1, 0);
            if (i == MAXC - 2) chk("full early fv", {31'b0, bus.frm_valid}, 32'd0);
        end
        chk("full fv",        {31'b0, bus.frm_valid},    32'd1);
        chk("full fcnt",      {28'b0, bus.frm_count},    32'd15);
        chk("full data[3:0]", {28'b0, bus.frm_data[3:0]}, 32'h9);
        chk("full dct_count", {28'b0, dct_count},        32'd0);
        cyc(1, 0, 0, 0, 1, 0);
        chk("full pulse", {31'b0, bus.frm_valid}, 32'd0);

        // Trace off drains a partial buffer, then codes are ignored.
        for (int i = 0; i < 5; i++) cyc(1, 1, 2'd1, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("trcoff fv",   {31'b0, bus.frm_valid}, 32'd1);
        chk("trcoff fcnt", {28'b0, bus.frm_count}, 32'd5);
        chk("trcoff data", {2'b0, bus.frm_data},   32'h155);
        for (int i = 0; i < 3; i++) cyc(0, 1, 2'd3, 0, 1, 0);
        chk("idle dct_count", {28'b0, dct_count}, 32'd0);

        // Backpressure, drop, clear, reload.
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 2'd1, 1, 0, 0);
        cyc(1, 1, 2'd2, 1, 0, 0);
        chk("bp held data", {2'b0, bus.frm_data},   32'h1);
        chk("bp held fv",   {31'b0, bus.frm_valid}, 32'd1);
        chk("bp ovf set",   {31'b0, overflow},      32'd1);
        cyc(1, 1, 2'd2, 1, 0, 1);
        chk("bp set wins",  {31'b0, overflow},      32'd1);
        cyc(1, 0, 0, 0, 0, 1);
        chk("bp ovf clr",   {31'b0, overflow},      32'd0);
        cyc(1, 1, 2'd3, 1, 1, 0);
        chk("reload data",  {2'b0, bus.frm_data},   32'h3);
        chk("reload ovf",   {31'b0, overflow},      32'd0);

        // Asynchronous reset mid-frame.
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 2'd1, 1, 0, 0);
        for (int i = 0; i < 7; i++) cyc(1, 1, 2'd2, 0, 0, 0);
        chk("pre-rst cnt", {28'b0, dct_count},     32'd7);
        chk("pre-rst fv",  {31'b0, bus.frm_valid}, 32'd1);
        do_reset();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 8) != 0, $urandom % 2, 2'($urandom), ($urandom % 8) == 0,
                $urandom % 2, ($urandom % 16) == 0);

`ifdef DCT_TIMESTAMP_EN
        do_reset();
        for (int i = 0; i < 100; i++) cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 1, 2'd1, 1, 1, 0);
        chk("ts 100", {16'b0, bus.frm_ts}, 32'd100);
        for (int i = 0; i < 65600; i++) cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 1, 2'd1, 1, 1, 0);
        chk("ts wrap", {16'b0, bus.frm_ts}, 32'((101 + 65600) % 65536));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/eindopdracht_nios2_qsys_0_oci_dct_packer.md
# eindopdracht_nios2_qsys_0_oci_dct_packer

Instruction-trace code packer for the Nios II OCI debug path. It accepts 2-bit per-instruction trace codes, packs them into a 30-bit accumulation buffer with a 4-bit occupancy count, and emits complete or flushed frames through a valid/ready handshake. It sits directly upstream of the OCI test bench, and its `dct_buffer`/`dct_count` outputs feed that monitor. Its frame port feeds the trace FIFO.

## Interface
- `MAX_CODES`, default 15: codes per full frame; legal range 1..15.
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `trc_on`  in  1  trace enable; codes are ignored while low.
- `code_valid`  in  1  `code` is valid this cycle.
- `code`  in  2  trace code; all four values are packed verbatim.
- `flush_req`  in  1  force emission of a partial buffer (indirect jump, exception).
- `dct_buffer`  out  30  live accumulation buffer; code i occupies bits [2i+1:2i], oldest at [1:0].
- `dct_count`  out  4  number of valid codes in `dct_buffer`, 0..`MAX_CODES`.
- `frm_valid`  out  1  an emitted frame is held.
- `frm_ready`  in  1  the consumer accepts the frame.
- `frm_data`  out  30  frame payload, in the same layout as `dct_buffer`.
- `frm_count`  out  4  number of codes in the frame, 1..`MAX_CODES`.
- `overflow`  out  1  sticky: a frame was dropped.
- `ovf_clr`  in  1  clears `overflow`.

## Operation
- Run FSM, states IDLE and RUN:
  - IDLE→RUN when `trc_on`=1.
  - RUN→IDLE when `trc_on`=0. On that edge, if `dct_count`>0, an implicit flush is performed.
- Accept: in RUN with `code_valid`=1, `code` is written at slot `dct_count` and the count increments. Unused slots read 0.
- Emit trigger, evaluated after the accept: `count_next`==`MAX_CODES`, OR (`flush_req`=1 OR implicit flush) AND `count_next`>0.
- Emit action:
  - The buffer and count are copied to the frame register, and `dct_buffer`/`dct_count` clear to 0.
  - When emit and accept coincide, the accepted code is included in the frame.
- Frame register states:
  - EMPTY→FULL on emit.
  - FULL→EMPTY on `frm_ready`.
  - FULL with `frm_ready`=1 and a simultaneous emit: the register reloads with the new frame, with no overflow.
- Overflow: an emit while FULL and `frm_ready`=0 drops the new frame and sets `overflow`. The accumulation buffer still clears, so codes keep being accepted. The held frame is unchanged.
- `ovf_clr`: when it coincides with a new drop, the set wins.
- `flush_req` with `count_next`=0 produces no frame.
- `code_valid` while IDLE is ignored; `dct_count` stays 0.
- While `frm_valid`=1, `frm_data`/`frm_count` remain stable until accepted.

## Timing
- Reset values: FSM=IDLE; `dct_buffer`=0, `dct_count`=0, `frm_valid`=0, `frm_data`=0, `frm_count`=0, `overflow`=0.
- Reset taking effect mid-frame discards the buffer and the frame register immediately.
- All outputs are registered. `dct_count` reflects an accept 1 cycle after the edge that samples it.
- Emit latency: `frm_valid` rises 1 cycle after the triggering input cycle.
- Throughput: 1 code per cycle. With `frm_ready` held high, 1 frame per `MAX_CODES` cycles sustained, no stalls.
- `frm_ready` is allowed to be high while `frm_valid`=0; it has no effect then.

## Configuration
- `DCT_TIMESTAMP_EN` defined:
  - Adds output `frm_ts` [15:0], plus a free-running 16-bit cycle counter that resets to 0 and wraps 0xFFFF→0.
  - On emit, `frm_ts` captures the counter value of the triggering cycle.
  - `frm_ts` is held with the frame and is 0 at reset.
- `DCT_TIMESTAMP_EN` undefined: neither the port nor the counter exists, and all other behaviour is identical.

## Test plan
- Full frame: `trc_on`=1, `frm_ready`=1, 15 codes 01,10,11,00,… back-to-back → a single `frm_valid` pulse, `frm_count`=15, `frm_data`[1:0]=01 and [3:2]=10; `dct_count` returns to 0 on the same edge.
- Flush with code: 3 codes 10, with `flush_req` asserted together with the 3rd → `frm_count`=3, `frm_data`=0x2A; `flush_req` alone with count 0 → no frame.
- Trace off: 5 codes, then `trc_on`=0 → frame with `frm_count`=5; later codes ignored, `dct_count` stays 0.
- Backpressure and overflow: `frm_ready`=0 across 2 emits → first frame held stable, `overflow`=1; pulse `ovf_clr` → 0. Reload: emit while `frm_ready`=1 and FULL → new frame, `overflow` stays 0.
- Reset: assert `reset_n`=0 mid-frame with `dct_count`=7 and `frm_valid`=1 → all outputs 0 immediately, without a clock edge.
- `DCT_TIMESTAMP_EN`: emit at cycle 100 after reset → `frm_ts`=100; run past 65535 cycles → wrapped value is correct.
